mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates one single-ported unified memory between the fetch stage (instruction reads) and the MEM stage (loads and stores).
- MEM-stage requests come from memtoregm/memwritem, with aluoutm as the address and writedatam as the store data.
- Sequences a variable-latency req/ready memory transaction.
- Generates per-requester stalls and detects memory timeouts.
- Sits between the pipeline registers and the external memory model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 255, max cycles in a BUSY state before abort (range 1..65535)

Ports:
clk  in  1  clock, all flops on rising edge
rst  in  1  asynchronous active-high reset
ireq  in  1  fetch read request, held until ivalid
iaddr  in  ADDR_W  fetch address
irdata  out  DATA_W  instruction returned, registered
ivalid  out  1  one-cycle completion pulse for fetch
istall  out  1  fetch must hold: ireq & ~ivalid
dreq  in  1  MEM-stage request (memtoregm|memwritem), held until dvalid
dwe  in  1  1 = store, 0 = load
daddr  in  ADDR_W  data address
dwdata  in  DATA_W  store data
drdata  out  DATA_W  load data returned, registered
dvalid  out  1  one-cycle completion pulse for MEM stage
dstall  out  1  pipeline must hold: dreq & ~dvalid
mem_req  out  1  memory request, registered
mem_we  out  1  memory write enable, registered
mem_addr  out  ADDR_W  memory address, registered
mem_wdata  out  DATA_W  memory write data, registered
mem_ready  in  1  memory completes the current access at this edge
mem_rdata  in  DATA_W  read data, valid when mem_ready=1
err  out  1  sticky timeout flag

Behaviour:
- The interface is one clock with asynchronous active-high reset.
- States: IDLE, BUSY_I, BUSY_D.
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE.
  - All outputs go to 0, including irdata, drdata, the mem_* outputs and err.
  - The wait counter goes to 0.
  - A memory transaction in flight is abandoned; mem_req drops immediately.
- Arbitration: evaluated at each edge in IDLE, and at the completing edge of a BUSY state.
  - Eligible requests are dreq with dvalid=0, and ireq with ivalid=0.
  - Fixed priority: D over I, because the MEM-stage instruction is older.
  - If D is granted: next state BUSY_D; mem_req<=1, mem_we<=dwe, mem_addr<=daddr, mem_wdata<=dwdata.
  - If I is granted: next state BUSY_I; mem_req<=1, mem_we<=0, mem_addr<=iaddr, mem_wdata unchanged.
  - If nothing is eligible: next state IDLE; mem_req<=0, mem_we<=0.
- BUSY_x with mem_ready=0:
  - Hold all mem_* outputs.
  - Wait counter += 1.
- BUSY_x with mem_ready=1 (completion):
  - BUSY_I: irdata<=mem_rdata, ivalid<=1.
  - BUSY_D load: drdata<=mem_rdata, dvalid<=1.
  - BUSY_D store: dvalid<=1, drdata unchanged.
  - Wait counter <= 0.
  - Re-arbitrate in the same edge, so back-to-back transactions have no idle gap.
- The completed requester is not eligible in the cycle its valid is high. This prevents a double grant while the pipeline advances.
- Valid pulses last exactly one cycle.
- Latency: a grant at edge N puts mem_req high after N. With mem_ready high at edge N+k, valid is high after edge N+k. Minimum is 1 cycle from grant to valid.
- Timeout: if the counter reaches TIMEOUT while still waiting, the abort happens at that edge:
  - The transaction is aborted and err<=1.
  - The owning valid is pulsed; rdata<=0 for a read.
  - mem_req<=0 and the state goes to IDLE for at least one cycle; there is no re-arbitration on that edge.
  - err stays set until reset.
- mem_ready while in IDLE is ignored.
- Request inputs are sampled only at grant. Changes to iaddr/daddr/dwdata during BUSY have no effect.
- istall and dstall are combinational from the inputs and the registered valids. There are no other combinational paths to mem_*.

Test Plan:
- Reset mid BUSY_D (rst pulsed between edges) -> mem_req, dvalid, err, drdata go to 0 immediately; after release, a pending dreq is re-granted at the first edge.
- Single fetch, iaddr=0x0000_0040, mem_ready high 3 cycles after mem_req, mem_rdata=0x2010_0005 -> ivalid one cycle, irdata=0x2010_0005, istall high until that cycle, mem_we=0 throughout.
- ireq and dreq together in IDLE, dwe=1, daddr=0x0000_0100, dwdata=0xCAFE_F00D -> D served first (mem_we=1, addr 0x100); I is granted on D's completion edge with no idle cycle; dvalid then ivalid, each 1 cycle; drdata unchanged.
- Load with mem_ready tied high, daddr=0x0000_0200, mem_rdata=0x1234_5678 -> dvalid the cycle after grant, drdata=0x1234_5678; no second grant while dvalid=1 even though dreq is still high.
- Timeout, TIMEOUT=4, mem_ready held low on a load -> after 4 wait cycles: err=1, dvalid pulse, drdata=0, state IDLE for 1 cycle; a later normal access succeeds with err still 1.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch stage
// and the MEM stage. MEM stage has fixed priority. It sequences a variable-latency
// req/ready access, returns registered data with one-cycle valid pulses,
// and aborts an access that waits too long (sticky err).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              ireq,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] irdata,
  output logic              ivalid,
  output logic              istall,
  // MEM-stage port
  input  logic              dreq,
  input  logic              dwe,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dwdata,
  output logic [DATA_W-1:0] drdata,
  output logic              dvalid,
  output logic              dstall,
  // memory side
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  // A 16-bit counter covers the full legal TIMEOUT range.
  localparam int                CNT_W   = 16;
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  // The abort fires on the edge where the count would reach TIMEOUT.
  localparam logic [CNT_W-1:0]  CNT_TOP = CNT_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   irdata_q, irdata_d;
  logic [DATA_W-1:0]   drdata_q, drdata_d;
  logic                ivalid_q, ivalid_d;
  logic                dvalid_q, dvalid_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;

  logic busy, done, abort, arb_en;
  logic i_elig, d_elig;

  // Completion/abort qualifiers and per-requester eligibility for this edge.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = busy & mem_ready;
    abort  = busy & ~mem_ready & (cnt_q >= CNT_TOP);
    // Re-arbitrate in IDLE or on a completion; never on an abort edge.
    arb_en = (state_q == IDLE) | done;
    // A requester finishing on this edge still holds its req, so mask it
    // out until its valid pulse has been seen.
    d_elig = dreq & ~dvalid_q & ~(done & (state_q == BUSY_D));
    i_elig = ireq & ~ivalid_q & ~(done & (state_q == BUSY_I));
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    ivalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    case (state_q)
      BUSY_I: begin
        if (mem_ready) begin
          irdata_d = mem_rdata;
          ivalid_d = 1'b1;
          cnt_d    = '0;
        end else if (abort) begin
          irdata_d  = '0;
          ivalid_d  = 1'b1;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      BUSY_D: begin
        // mem_we_q still holds the access type latched at grant.
        if (mem_ready) begin
          if (!mem_we_q) drdata_d = mem_rdata;
          dvalid_d = 1'b1;
          cnt_d    = '0;
        end else if (abort) begin
          if (!mem_we_q) drdata_d = '0;
          dvalid_d  = 1'b1;
          err_d     = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: ;
    endcase

    if (arb_en) begin
      if (d_elig) begin
        state_d     = BUSY_D;
        mem_req_d   = 1'b1;
        mem_we_d    = dwe;
        mem_addr_d  = daddr;
        mem_wdata_d = dwdata;
      end else if (i_elig) begin
        state_d    = BUSY_I;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = iaddr;
      end else begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    end
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      irdata_q    <= '0;
      drdata_q    <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
      ivalid_q    <= ivalid_d;
      dvalid_q    <= dvalid_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign irdata    = irdata_q;
  assign ivalid    = ivalid_q;
  assign drdata    = drdata_q;
  assign dvalid    = dvalid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Stalls are the only combinational outputs: request pending, no valid yet.
  assign istall = ireq & ~ivalid_q;
  assign dstall = dreq & ~dvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner
// sequences (timeout, async reset mid-access), then randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, mem_ready = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dwdata = '0, mem_rdata = '0;
  logic [31:0] irdata, drdata, mem_addr, mem_wdata;
  logic        ivalid, istall, dvalid, dstall, mem_req, mem_we, err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .ivalid(ivalid), .istall(istall),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
    .drdata(drdata), .dvalid(dvalid), .dstall(dstall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic ireq; logic [31:0] iaddr;
    logic dreq; logic dwe; logic [31:0] daddr; logic [31:0] dwdata;
    logic rdy; logic [31:0] rdata;
    logic e_req; logic e_we; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic e_iv; logic e_dv; logic [31:0] e_ird; logic [31:0] e_drd;
    logic e_ist; logic e_dst;
  } vec_t;

  vec_t vt [13];

  // ---------------- reference model ----------------
  // owner: 0 nobody, 1 fetch, 2 MEM stage. waited: edges spent without ready.
  int          owner, waited;
  logic [31:0] m_ird, m_drd, m_addr, m_wdata;
  logic        m_iv, m_dv, m_req, m_we, m_err;

  task automatic model_reset();
    owner = 0; waited = 0;
    m_ird = '0; m_drd = '0; m_addr = '0; m_wdata = '0;
    m_iv = 1'b0; m_dv = 1'b0; m_req = 1'b0; m_we = 1'b0; m_err = 1'b0;
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    int   fin;
    bit   ab;
    logic niv, ndv;
    fin = 0; ab = 0; niv = 1'b0; ndv = 1'b0;
    if (owner != 0) begin
      if (mem_ready) begin
        fin = owner;
        if (owner == 1) begin m_ird = mem_rdata; niv = 1'b1; end
        else begin if (!m_we) m_drd = mem_rdata; ndv = 1'b1; end
        waited = 0;
      end else if (waited + 1 >= TO) begin
        ab = 1; m_err = 1'b1;
        if (owner == 1) begin m_ird = '0; niv = 1'b1; end
        else begin if (!m_we) m_drd = '0; ndv = 1'b1; end
        owner = 0; waited = 0; m_req = 1'b0; m_we = 1'b0;
      end else begin
        waited++;
      end
    end
    if (!ab && (owner == 0 || fin != 0)) begin
      if (dreq && !m_dv && fin != 2) begin
        owner = 2; m_req = 1'b1; m_we = dwe; m_addr = daddr; m_wdata = dwdata;
      end else if (ireq && !m_iv && fin != 1) begin
        owner = 1; m_req = 1'b1; m_we = 1'b0; m_addr = iaddr;
      end else begin
        owner = 0; m_req = 1'b0; m_we = 1'b0;
      end
    end
    m_iv = niv;
    m_dv = ndv;
  endtask

  logic [134:0] act_v, exp_v;

  initial begin
    vt[0]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vt[1]  = vt[0];
    vt[2]  = vt[0];
    vt[3]  = '{1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h2010_0005,
               1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h2010_0005, 32'h0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h2010_0005, 32'h0, 1'b0, 1'b0};
    vt[5]  = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 1'b0, 32'h0,
               1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h2010_0005, 32'h0, 1'b1, 1'b1};
    vt[6]  = '{1'b1, 32'h80, 1'b1, 1'b1, 32'h100, 32'hCAFE_F00D, 1'b1, 32'hDEAD_BEEF,
               1'b1, 1'b0, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b1, 32'h2010_0005, 32'h0, 1'b1, 1'b0};
    vt[7]  = '{1'b1, 32'h80, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h1111_2222,
               1'b0, 1'b0, 32'h80, 32'hCAFE_F00D, 1'b1, 1'b0, 32'h1111_2222, 32'h0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h80, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h1111_2222, 32'h0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h1234_5678,
               1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h1111_2222, 32'h0, 1'b0, 1'b1};
    vt[10] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h1234_5678,
               1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b1, 32'h1111_2222, 32'h1234_5678, 1'b0, 1'b0};
    vt[11] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h1234_5678,
               1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h1111_2222, 32'h1234_5678, 1'b0, 1'b1};
    vt[12] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h200, 32'h0, 1'b0, 1'b0, 32'h1111_2222, 32'h1234_5678, 1'b0, 1'b0};

    // reset state
    #1;
    chk("reset_outputs", {20'h0, mem_req, mem_we, ivalid, dvalid, err, istall, dstall,
                          |mem_addr, |mem_wdata, |irdata, |drdata, 1'b0}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // table: single fetch, D-over-I with back-to-back grant, ready-tied load
    for (int i = 0; i < 13; i++) begin
      ireq = vt[i].ireq; iaddr = vt[i].iaddr;
      dreq = vt[i].dreq; dwe = vt[i].dwe; daddr = vt[i].daddr; dwdata = vt[i].dwdata;
      mem_ready = vt[i].rdy; mem_rdata = vt[i].rdata;
      step();
      chk($sformatf("vec%0d_memctl", i), {29'h0, mem_req, mem_we, 1'b0},
          {29'h0, vt[i].e_req, vt[i].e_we, 1'b0});
      chk($sformatf("vec%0d_addr", i), mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_wdata", i), mem_wdata, vt[i].e_wdata);
      chk($sformatf("vec%0d_valid_stall", i), {28'h0, ivalid, dvalid, istall, dstall},
          {28'h0, vt[i].e_iv, vt[i].e_dv, vt[i].e_ist, vt[i].e_dst});
      chk($sformatf("vec%0d_irdata", i), irdata, vt[i].e_ird);
      chk($sformatf("vec%0d_drdata", i), drdata, vt[i].e_drd);
    end

    // timeout on a load with a fetch waiting behind it
    ireq = 1'b1; iaddr = 32'h44;
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h300; dwdata = 32'h55;
    mem_ready = 1'b0; mem_rdata = 32'h9999_9999;
    step();
    chk("to_grant_req", {31'h0, mem_req}, 32'h1);
    chk("to_grant_addr", mem_addr, 32'h300);
    for (int w = 1; w < TO; w++) begin
      step();
      chk($sformatf("to_wait%0d", w), {29'h0, mem_req, err, dvalid}, {29'h0, 1'b1, 1'b0, 1'b0});
    end
    step();
    chk("to_abort_flags", {28'h0, err, dvalid, mem_req, ivalid}, {28'h0, 1'b1, 1'b1, 1'b0, 1'b0});
    chk("to_abort_drdata", drdata, 32'h0);
    dreq = 1'b0;
    step();
    chk("to_after_grant_i", {29'h0, mem_req, mem_we, err}, {29'h0, 1'b1, 1'b0, 1'b1});
    chk("to_after_addr", mem_addr, 32'h44);
    mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
    step();
    chk("to_after_done", {29'h0, ivalid, err, mem_req}, {29'h0, 1'b1, 1'b1, 1'b0});
    chk("to_after_irdata", irdata, 32'hA5A5_0001);
    ireq = 1'b0; mem_ready = 1'b0;
    step();

    // asynchronous reset in the middle of a load
    dreq = 1'b1; dwe = 1'b0; daddr = 32'h400;
    step();
    chk("rst_pre_req", {31'h0, mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_flags", {28'h0, mem_req, dvalid, err, ivalid}, 32'h0);
    chk("rst_async_drdata", drdata, 32'h0);
    chk("rst_async_irdata", irdata, 32'h0);
    chk("rst_async_addr", mem_addr, 32'h0);
    #2 rst = 1'b0;
    step();
    chk("rst_regrant_req", {31'h0, mem_req}, 32'h1);
    chk("rst_regrant_addr", mem_addr, 32'h400);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0077;
    step();
    chk("rst_regrant_done", {31'h0, dvalid}, 32'h1);
    chk("rst_regrant_drdata", drdata, 32'h77);
    dreq = 1'b0; mem_ready = 1'b0;
    step();

    // randomized traffic against the model
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    ireq = 1'b0; dreq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!(ireq && !m_iv)) ireq = ($urandom_range(0, 9) < 5);
      if (!(dreq && !m_dv)) dreq = ($urandom_range(0, 9) < 5);
      iaddr = $urandom; daddr = $urandom; dwdata = $urandom;
      dwe = $urandom_range(0, 1) == 1;
      mem_ready = ($urandom_range(0, 9) < 5);
      mem_rdata = $urandom;
      @(posedge clk);
      model_edge();
      #1;
      act_v = {mem_req, mem_we, mem_addr, mem_wdata, ivalid, dvalid, irdata, drdata,
               err, istall, dstall};
      exp_v = {m_req, m_we, m_addr, m_wdata, m_iv, m_dv, m_ird, m_drd,
               m_err, ireq & ~m_iv, dreq & ~m_dv};
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL rand_cycle%0d: got %h expected %h", c, act_v, exp_v);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
